// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer.
// Runs a shift-add multiply or a restoring divide on operand magnitudes, one
// bit per cycle, then applies sign correction and writes HI/LO. The stall
// output holds the requesting instruction in E until the result is written.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } stateT;

  stateT stateReg, stateNext;

  logic [CNT_W-1:0] cntReg;
  // accReg: product upper half / partial remainder
  // lowReg: multiplier being consumed / quotient being built
  // opReg : multiplicand / divisor magnitude
  logic [WIDTH-1:0] accReg, lowReg, opReg;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             isDivReg, resNegReg, remNegReg, divZeroReg;

  // Operand magnitudes and signs at acceptance time
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] magA, magB;
  assign aNeg = is_signed & srca[WIDTH-1];
  assign bNeg = is_signed & srcb[WIDTH-1];
  assign magA = aNeg ? -srca : srca;
  assign magB = bNeg ? -srcb : srcb;

  // Multiply step: conditional add into the upper half, carry kept in bit WIDTH
  logic [WIDTH:0] mulSum;
  assign mulSum = {1'b0, accReg} + (lowReg[0] ? {1'b0, opReg} : '0);

  // Divide step: shift the remainder left pulling in the next dividend bit
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divRem;
  assign divShift = {accReg, lowReg[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opReg};
  assign divRem   = WIDTH'(divShift - {1'b0, opReg});

  // Sign-corrected results presented in FINISH
  logic [2*WIDTH-1:0] prodMag, prodRes;
  logic [WIDTH-1:0]   quoRes, remRes;
  assign prodMag = {accReg, lowReg};
  assign prodRes = resNegReg ? -prodMag : prodMag;
  assign quoRes  = divZeroReg ? '1 : (resNegReg ? -lowReg : lowReg);
  assign remRes  = remNegReg ? -accReg : accReg;

  logic lastIter;
  assign lastIter = (cntReg == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Next-state and handshake outputs; start/abort act combinationally in IDLE
  always_comb begin
    stateNext = stateReg;
    stall     = 1'b0;
    done      = 1'b0;
    busy      = (stateReg != IDLE);
    case (stateReg)
      IDLE: begin
        stall = start;
        if (start && !abort) stateNext = RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (abort)         stateNext = IDLE;
        else if (lastIter) stateNext = FINISH;
      end
      FINISH: begin
        done      = ~abort;
        stall     = abort;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, then commit HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cntReg     <= '0;
      accReg     <= '0;
      lowReg     <= '0;
      opReg      <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      isDivReg   <= 1'b0;
      resNegReg  <= 1'b0;
      remNegReg  <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start && !abort) begin
            cntReg     <= '0;
            accReg     <= '0;
            isDivReg   <= is_div;
            resNegReg  <= aNeg ^ bNeg;
            remNegReg  <= aNeg;
            divZeroReg <= is_div && (srcb == '0);
            lowReg     <= is_div ? magA : magB;
            opReg      <= is_div ? magB : magA;
          end
        end
        RUN: begin
          cntReg <= cntReg + CNT_W'(1);
          if (isDivReg) begin
            accReg <= divFits ? divRem : divShift[WIDTH-1:0];
            lowReg <= {lowReg[WIDTH-2:0], divFits};
          end else begin
            accReg <= mulSum[WIDTH:1];
            lowReg <= {mulSum[0], lowReg[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (!abort) begin
            if (isDivReg) begin
              hiReg <= remRes;
              loReg <= quoRes;
            end else begin
              hiReg <= prodRes[2*WIDTH-1:WIDTH];
              loReg <= prodRes[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hiReg;
  assign lo = loReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a cycle-count reference model
// with arithmetic results is compared every cycle, and directed operations
// check literal HI/LO values, stall length and done timing.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, is_div, is_signed, abort;
  logic [W-1:0] srca, srcb;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .is_div(is_div),
    .is_signed(is_signed), .srca(srca), .srcb(srcb), .abort(abort),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Arithmetic reference: {hi, lo} for one operation
  function automatic logic [63:0] refResult(input bit d, input bit s,
                                            input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              qa, qb, q, r;
    if (!d) begin
      if (s) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      up = {32'b0, a} * {32'b0, b};
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (s) begin
      qa = $signed(a);
      qb = $signed(b);
      q  = qa / qb;
      r  = qa % qb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Reference timeline: phase 0 idle, 1..W iterating, W+1 writing results
  int           mPhase = 0;
  logic [W-1:0] mHi = '0, mLo = '0, mPendHi = '0, mPendLo = '0;

  // Advance the reference on each active edge
  always @(posedge clk) begin
    if (reset) begin
      mPhase <= 0;
      mHi    <= '0;
      mLo    <= '0;
    end else if (mPhase == 0) begin
      if (start && !abort) begin
        {mPendHi, mPendLo} <= refResult(is_div, is_signed, srca, srcb);
        mPhase <= 1;
      end
    end else if (abort) begin
      mPhase <= 0;
    end else if (mPhase == W + 1) begin
      mHi    <= mPendHi;
      mLo    <= mPendLo;
      mPhase <= 0;
    end else begin
      mPhase <= mPhase + 1;
    end
  end

  // Compare DUT against the reference mid-cycle
  always @(negedge clk) begin
    logic expStall, expBusy, expDone;
    if (checkEn) begin
      expBusy  = (mPhase != 0);
      expStall = (mPhase == 0 && start) || (mPhase >= 1 && mPhase <= W) ||
                 (mPhase == W + 1 && abort);
      expDone  = (mPhase == W + 1) && !abort;
      check("cyc_busy_stall_done", {61'b0, busy, stall, done}, {61'b0, expBusy, expStall, expDone});
      check("cyc_hi", {32'b0, hi}, {32'b0, mHi});
      check("cyc_lo", {32'b0, lo}, {32'b0, mLo});
    end
  end

  // One operation; optional ignored restart, abort or reset at a given cycle
  task automatic runOp(input string name, input bit d, input bit s,
                       input logic [31:0] a, input logic [31:0] b,
                       input int injectAt, input int abortAt, input int resetAt,
                       input bit expectDone, input logic [31:0] expHi, input logic [31:0] expLo);
    int stallCnt = 0;
    int doneAt   = -1;
    if (expectDone) check({name, "_model"}, refResult(d, s, a, b), {expHi, expLo});
    @(posedge clk); #1;
    start = 1'b1; is_div = d; is_signed = s; srca = a; srcb = b;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (done && doneAt < 0) doneAt = cyc;
      if (cyc == abortAt + 1 || cyc == resetAt + 1)
        check({name, "_idle_after"}, {62'b0, busy, stall}, 64'd0);
      @(posedge clk); #1;
      start = (cyc + 1 == injectAt);
      abort = (cyc + 1 == abortAt);
      reset = (cyc + 1 == resetAt);
      if (cyc + 1 == injectAt) begin
        srca = 32'd100;
        srcb = 32'd100;
      end
      if (expectDone && doneAt >= 0) break;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    if (expectDone) begin
      check({name, "_done_cycle"}, 64'(doneAt), 64'(W + 1));
      check({name, "_stall_cycles"}, 64'(stallCnt), 64'(W + 1));
    end else begin
      check({name, "_no_done"}, 64'(doneAt), 64'hFFFF_FFFF_FFFF_FFFF);
    end
    check({name, "_hi"}, {32'b0, hi}, {32'b0, expHi});
    check({name, "_lo"}, {32'b0, lo}, {32'b0, expLo});
    $display("op %s: a=%h b=%h div=%0d signed=%0d -> hi=%h lo=%h done_at=%0d stall_cycles=%0d",
             name, a, b, d, s, hi, lo, doneAt, stallCnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_div = 1'b0; is_signed = 1'b0;
    abort = 1'b0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {61'b0, busy, stall, done}, 64'd0);
    $display("op reset: hi=%h lo=%h busy=%0d stall=%0d", hi, lo, busy, stall);

    runOp("multu_ffff_x2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, -100, -100, -100, 1'b1, 32'h1, 32'hFFFF_FFFE);
    runOp("mult_m3_x5",    1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, -100, -100, -100, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("mult_min_xm1",  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -100, -100, -100, 1'b1, 32'h0, 32'h8000_0000);
    runOp("div_m7_2",      1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -100, -100, -100, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu_100_7",    1'b1, 1'b0, 32'd100, 32'd7, -100, -100, -100, 1'b1, 32'd2, 32'd14);
    runOp("div_ovf",       1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -100, -100, -100, 1'b1, 32'h0, 32'h8000_0000);
    runOp("divu_by_zero",  1'b1, 1'b0, 32'h1234, 32'd0, -100, -100, -100, 1'b1, 32'h1234, 32'hFFFF_FFFF);
    runOp("div_abort",     1'b1, 1'b0, 32'd50, 32'd3, -100, 10, -100, 1'b0, 32'h1234, 32'hFFFF_FFFF);
    runOp("mult_restart",  1'b0, 1'b0, 32'd6, 32'd7, 5, -100, -100, 1'b1, 32'd0, 32'd42);
    runOp("mult_reset",    1'b0, 1'b0, 32'd9, 32'd9, -100, -100, 20, 1'b0, 32'd0, 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the pipeline's HI/LO multiply/divide resource.
- Accepts an operation from the Execute stage and runs a shift-add multiply or restoring divide, one bit per cycle.
- Holds the pipeline with a stall request while busy, then updates the HI/LO registers.
- Sits beside the datapath ALU; the hazard unit ORs its stall output into the F/D stall and E-stage flush logic.

Parameters:
- WIDTH, 32, operand width; also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage request; qualified by multordivE and not flushE upstream
- is_div  input  1  1 = divide, 0 = multiply
- is_signed  input  1  1 = two's-complement operation (mult/div), 0 = unsigned (multu/divu)
- srca  input  WIDTH  rs operand (multiplicand / dividend)
- srcb  input  WIDTH  rt operand (multiplier / divisor)
- abort  input  1  cancel the in-flight operation (exception/flush)
- stall  output  1  pipeline hold request
- busy  output  1  sequencer not IDLE
- done  output  1  one-cycle pulse when HI/LO are updated
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset: state=IDLE, cnt=0, hi=0, lo=0, done=0, busy=0, stall=0. Reset mid-operation discards the operation; HI/LO are cleared.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 (cycle 0):
  - Latch magnitudes of srca/srcb (absolute value when is_signed and MSB set).
  - Latch result signs: quotient/product sign = sa^sb; remainder sign = sa.
  - Clear the accumulator, set cnt=0, go to RUN.
- stall = (IDLE & start) | RUN | (FINISH & ~done-registered). stall is combinational from start so the requesting instruction holds in E from cycle 0.
- RUN: one iteration per cycle.
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half; shift {acc, mplier} right by 1 (WIDTH+1-bit add, carry kept).
  - Divide: shift {rem, quo} left by 1; trial-subtract the divisor; if the result is non-negative, keep it and set quo LSB.
  - cnt increments; when cnt==WIDTH-1, go to FINISH.
- FINISH (cycle WIDTH+1):
  - Apply sign correction: negate the 2*WIDTH product if its sign is set; negate the quotient/remainder per their latched signs.
  - Write hi/lo, pulse done=1, drop stall, return to IDLE.
  - Total: stall high for cycles 0..WIDTH (WIDTH+1 cycles); HI/LO visible from cycle WIDTH+2.
- Divide by zero: no trap; run full latency; result hi=srca (unmodified), lo={WIDTH{1'b1}}.
- Signed overflow (most-negative / -1): lo=most-negative value, hi=0.
- start while busy: ignored; no re-latch.
- abort in RUN or FINISH: return to IDLE next cycle, no HI/LO write, no done pulse, stall deasserts next cycle. abort in IDLE with start=1: operation not accepted.
- abort and start in the same IDLE cycle: abort wins.
- hi/lo change only in FINISH or on reset.

Test Plan:
- Reset, unsigned multiply 0xFFFFFFFF × 0x00000002 -> stall high exactly 33 cycles, done pulses at cycle 33, hi=0x00000001, lo=0xFFFFFFFE.
- Signed multiply -3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed -0x80000000 × -1 -> hi=0x00000000, lo=0x80000000.
- Signed divide -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned divide 100 / 7 -> lo=14, hi=2.
- Divide by zero (srca=0x1234, srcb=0) -> same latency, hi=0x00001234, lo=0xFFFFFFFF.
- Assert abort at cycle 10 of a divide -> busy/stall low at cycle 11, no done, hi/lo keep prior values. Second start with new operands at cycle 5 of a multiply -> ignored, result matches the first operands.
- Assert reset at cycle 20 of a multiply -> next cycle IDLE, hi=lo=0, stall=0, done never pulses.
